// File: rtl/pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Purpose:
//   Chooses the next PC value and its load enable for the fetch PC register.
//   Covers sequential fetch, EX-stage branch redirects, interrupt entry
//   (RUN -> [DRAIN] -> TRAP -> HANDLER) and the return from the handler (mret).
//   While a bus transaction is stalled (stall_AXI), an accepted interrupt waits
//   in DRAIN so the outstanding access can complete before the redirect.
//
// Optional feature (macro PC_DRAIN_TIMEOUT_EN):
//   Adds an 8-bit DRAIN cycle counter. When it reaches DRAIN_MAX, the trap is
//   forced with cause 3 and the bus_timeout output pulses in the TRAP cycle.
//   Without the macro there is no counter and no bus_timeout port, and DRAIN
//   waits for stall_AXI to release.
//
// Parameters:
//   RESET_VEC  PC load value while rst is high
//   TRAP_VEC   interrupt handler entry address
//   DRAIN_MAX  DRAIN cycles before a bus timeout (timeout build only)
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   pc_cur, pc_plus4   current PC register value and sequential next PC
//   br_taken/br_target EX-stage redirect request and its target
//   mret               one-cycle return-from-handler pulse
//   stall_CPU          hazard stall (a branch may override it)
//   stall_AXI          bus stall (nothing overrides it)
//   tim_irq, ext_irq   level interrupt requests (ext has priority)
//   irq_en             global interrupt enable
//   next_pc, pc_we     PC register D value and load enable
//   flush              kill IF/ID/EX
//   trap_take          one-cycle pulse in the TRAP cycle
//   mepc, cause        saved return address and trap cause
//                      (1 timer, 2 external, 3 bus timeout)
//   bus_timeout        timeout-build only; pulses in a timeout TRAP cycle
//   in_handler         high while the interrupt handler runs
// -----------------------------------------------------------------------------
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0000,
  parameter logic [7:0]  DRAIN_MAX = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic [31:0] pc_plus4,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        mret,
  input  logic        stall_CPU,
  input  logic        stall_AXI,
  input  logic        tim_irq,
  input  logic        ext_irq,
  input  logic        irq_en,
  output logic [31:0] next_pc,
  output logic        pc_we,
  output logic        flush,
  output logic        trap_take,
  output logic [31:0] mepc,
  output logic [1:0]  cause,
`ifdef PC_DRAIN_TIMEOUT_EN
  output logic        bus_timeout,
`endif
  output logic        in_handler
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_TRAP,
    ST_HANDLER
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_mepc;
  logic [1:0]  r_cause;
  logic [1:0]  r_pend_cause;
  logic [1:0]  w_pend_cause_next;
  logic        r_mret_pend;
  logic        w_mret_pend_next;
  // A branch seen while the PC is frozen for a pending trap is remembered so
  // the handler returns to the branch target even if upstream drops br_taken.
  logic        r_br_valid;
  logic        w_br_valid_next;
  logic [31:0] r_br_tgt;
  logic [31:0] w_br_tgt_next;

  logic        w_irq;
  logic [1:0]  w_irq_cause;
  logic        w_run_we;
  logic [31:0] w_run_pc;
  logic        w_mret_req;
  logic        w_timeout;

  assign w_irq       = irq_en && (ext_irq || tim_irq);
  assign w_irq_cause = ext_irq ? 2'd2 : 2'd1;
  // Branch overrides a hazard stall but never a bus stall.
  assign w_run_we    = !(stall_CPU || stall_AXI) || (br_taken && !stall_AXI);
  assign w_run_pc    = br_taken ? br_target : pc_plus4;
  assign w_mret_req  = mret || r_mret_pend;

`ifdef PC_DRAIN_TIMEOUT_EN
  logic [7:0] r_drain_cnt;
  logic [7:0] w_cnt_inc;
  logic       r_to_trap;

  assign w_cnt_inc = r_drain_cnt + 8'd1;
  assign w_timeout = (r_state == ST_DRAIN) && (w_cnt_inc == DRAIN_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain_cnt <= 8'd0;
      r_to_trap   <= 1'b0;
    end else begin
      // Held at zero outside DRAIN, so every DRAIN entry starts from zero.
      r_drain_cnt <= (r_state == ST_DRAIN) ? w_cnt_inc : 8'd0;
      // A DRAIN exit while the bus is still stalled can only be the timeout.
      r_to_trap   <= (r_state == ST_DRAIN) && (w_state_next == ST_TRAP) && stall_AXI;
    end
  end

  assign bus_timeout = (r_state == ST_TRAP) && r_to_trap && !rst;
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next      = r_state;
    next_pc           = w_run_pc;
    pc_we             = 1'b0;
    flush             = 1'b0;
    trap_take         = 1'b0;
    w_pend_cause_next = r_pend_cause;
    w_mret_pend_next  = r_mret_pend;
    w_br_valid_next   = r_br_valid;
    w_br_tgt_next     = r_br_tgt;

    case (r_state)
      ST_RUN: begin
        if (w_irq) begin
          // PC is frozen on acceptance; the trap performs the redirect.
          w_pend_cause_next = w_irq_cause;
          if (br_taken) begin
            w_br_valid_next = 1'b1;
            w_br_tgt_next   = br_target;
          end
          w_state_next = stall_AXI ? ST_DRAIN : ST_TRAP;
        end else begin
          pc_we = w_run_we;
        end
      end

      ST_DRAIN: begin
        if (br_taken) begin
          w_br_valid_next = 1'b1;
          w_br_tgt_next   = br_target;
        end
        if (!w_irq) begin
          w_state_next    = ST_RUN;
          w_br_valid_next = 1'b0;
        end else if (!stall_AXI) begin
          // Source is re-evaluated at the cycle the bus releases.
          w_pend_cause_next = w_irq_cause;
          w_state_next      = ST_TRAP;
        end else if (w_timeout) begin
          w_pend_cause_next = 2'd3;
          w_state_next      = ST_TRAP;
        end
      end

      ST_TRAP: begin
        next_pc         = TRAP_VEC;
        pc_we           = 1'b1;
        flush           = 1'b1;
        trap_take       = 1'b1;
        w_br_valid_next = 1'b0;
        w_state_next    = ST_HANDLER;
      end

      ST_HANDLER: begin
        // Interrupts are masked here; only mret leaves the handler.
        if (w_mret_req && !stall_AXI) begin
          next_pc          = r_mepc;
          pc_we            = 1'b1;
          flush            = 1'b1;
          w_mret_pend_next = 1'b0;
          w_state_next     = ST_RUN;
        end else begin
          pc_we = w_run_we;
          if (mret) begin
            w_mret_pend_next = 1'b1;
          end
        end
      end

      default: begin
        w_state_next = ST_RUN;
      end
    endcase

    if (rst) begin
      w_state_next      = ST_RUN;
      next_pc           = RESET_VEC;
      pc_we             = 1'b1;
      flush             = 1'b1;
      trap_take         = 1'b0;
      w_pend_cause_next = 2'd0;
      w_mret_pend_next  = 1'b0;
      w_br_valid_next   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_mepc       <= RESET_VEC;
      r_cause      <= 2'd0;
      r_pend_cause <= 2'd0;
      r_mret_pend  <= 1'b0;
      r_br_valid   <= 1'b0;
      r_br_tgt     <= 32'd0;
    end else begin
      r_state      <= w_state_next;
      r_pend_cause <= w_pend_cause_next;
      r_mret_pend  <= w_mret_pend_next;
      r_br_valid   <= w_br_valid_next;
      r_br_tgt     <= w_br_tgt_next;
      if (r_state == ST_TRAP) begin
        r_mepc  <= br_taken ? br_target : (r_br_valid ? r_br_tgt : pc_cur);
        r_cause <= r_pend_cause;
      end
    end
  end

  assign mepc       = rst ? RESET_VEC : r_mepc;
  assign cause      = rst ? 2'd0 : r_cause;
  assign in_handler = (r_state == ST_HANDLER) && !rst;

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0000_0000, the PC load value while rst is high.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0000, the interrupt handler entry address.
REQ-003 SHALL have parameter DRAIN_MAX, default 8'd255, the maximum number of DRAIN cycles before a bus timeout (used only with the REQ-029 macro).
REQ-004 SHALL have port clk, input, 1, clock; all state updates on posedge.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have ports pc_cur [31:0] input (current PC register value) and pc_plus4 [31:0] input (sequential next PC).
REQ-007 SHALL have ports br_taken, input, 1, and br_target [31:0], input: the EX-stage redirect request and its target.
REQ-008 SHALL have port mret, input, 1, a one-cycle pulse that returns from the handler.
REQ-009 SHALL have inputs stall_CPU (1, hazard stall), stall_AXI (1, bus stall), tim_irq (1, level), ext_irq (1, level) and irq_en (1, global enable).
REQ-010 SHALL have outputs next_pc [31:0], the PC register D value, and pc_we (1), the PC load enable.
REQ-011 SHALL have outputs flush (1, kill IF/ID/EX), trap_take (1, one-cycle pulse), mepc [31:0], cause [1:0] and in_handler (1).

Function
REQ-012 SHALL implement FSM states RUN, DRAIN, TRAP and HANDLER.
REQ-013 RUN with no accepted interrupt: pc_we = !(stall_CPU||stall_AXI) || (br_taken && !stall_AXI).
REQ-014 RUN next_pc: br_target if br_taken, else pc_plus4; branch overrides stall_CPU, never stall_AXI (upstream holds br_taken during stall_AXI).
REQ-015 Interrupt accepted in RUN or DRAIN when irq_en && (ext_irq||tim_irq); ext_irq has priority over tim_irq (cause 2'd2 ext, 2'd1 timer).
REQ-016 RUN to TRAP on acceptance if stall_AXI=0; RUN to DRAIN on acceptance if stall_AXI=1; pc_we=0 in DRAIN.
REQ-017 DRAIN to TRAP on the first cycle with stall_AXI=0; the cause source is re-evaluated at that cycle.
REQ-018 DRAIN returns to RUN if both irq lines drop or irq_en clears before stall_AXI releases (no trap).
REQ-019 TRAP lasts exactly one cycle, with next_pc=TRAP_VEC, pc_we=1, flush=1 and trap_take=1.
REQ-020 TRAP latches mepc = br_target if br_taken that cycle, else pc_cur, latches cause, and then enters HANDLER.
REQ-021 HANDLER behaves like RUN for sequencing, with in_handler=1 and all interrupts masked (no nesting).
REQ-022 HANDLER on mret with stall_AXI=0: next_pc=mepc, pc_we=1, flush=1, next state RUN.
REQ-023 HANDLER holds an mret arriving under stall_AXI pending and executes it the first cycle stall_AXI=0.
REQ-024 mret outside HANDLER SHALL be ignored.
REQ-025 A branch and an interrupt in the same cycle: the trap wins and mepc=br_target.
REQ-026 The trap-to-PC latency is one clock: the PC equals TRAP_VEC at the edge after TRAP.

Reset
REQ-027 rst high SHALL force state=RUN, next_pc=RESET_VEC, pc_we=1, flush=1, trap_take=0, mepc=RESET_VEC, cause=0, in_handler=0 and clear the pending mret.
REQ-028 rst mid-DRAIN, mid-TRAP or in HANDLER SHALL abandon the trap with no trap_take pulse after release.

Configuration
REQ-029 Macro PC_DRAIN_TIMEOUT_EN defined SHALL add an 8-bit DRAIN counter, cleared on DRAIN entry.
REQ-030 With PC_DRAIN_TIMEOUT_EN, when the count reaches DRAIN_MAX the block SHALL enter TRAP regardless of stall_AXI, with cause=2'd3.
REQ-031 With PC_DRAIN_TIMEOUT_EN, a bus_timeout output (1) SHALL pulse in that TRAP cycle.
REQ-032 Macro PC_DRAIN_TIMEOUT_EN undefined SHALL remove the counter and the bus_timeout port, and DRAIN waits indefinitely.

Verification
REQ-033 rst 2 cycles, then free run -> next_pc=0, then 4, 8, with pc_we=1 each cycle.
REQ-034 pc_cur=0x40, tim_irq=1, irq_en=1, stall_AXI=0 -> TRAP next cycle, next_pc=TRAP_VEC, mepc=0x40, cause=1, trap_take for 1 cycle.
REQ-035 ext_irq and tim_irq together with stall_AXI=1 for 5 cycles -> 5 DRAIN cycles with pc_we=0, then TRAP with cause=2.
REQ-036 br_taken target 0x100 in the same cycle as tim_irq -> mepc=0x100; later mret -> next_pc=0x100, flush=1, state RUN.
REQ-037 tim_irq held in HANDLER -> no second trap; mret under stall_AXI for 3 cycles -> next_pc=mepc on the 4th cycle.
REQ-038 With PC_DRAIN_TIMEOUT_EN, stall_AXI stuck high -> TRAP after DRAIN_MAX cycles, cause=3, bus_timeout pulses once.
